mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits between EX and the writeback stage.
- Accepts one instruction at a time from the EX/MEM boundary and, for loads and stores, performs one word-aligned data-memory transaction with a request/response handshake.
- Produces the MEM/WB register contents the writeback stage consumes: raw read word, byte-lane read mask, ALU result, valid, and passthrough sideband.
- Byte/half extraction and sign extension stay in writeback; this block delivers only the raw 32-bit word plus rmask.

Parameters:
PASS_W, 64, width of opaque sideband (control word, rd, pc, etc.) carried unchanged from input to output

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  EX/MEM entry holds a live instruction
in_ready  out  1  stage can accept this cycle
in_alu_out  in  32  ALU result; byte address for memory ops
in_rs2  in  32  store data, unshifted
in_funct3  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_is_load  in  1  instruction is a load
in_is_store  in  1  instruction is a store
in_pass  in  PASS_W  sideband passthrough
dmem_read  out  1  read request, held until dmem_resp
dmem_write  out  1  write request, held until dmem_resp
dmem_address  out  32  {addr[31:2],2'b00}
dmem_wdata  out  32  store data shifted into lanes
dmem_byte_enable  out  4  store lane mask
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  transaction complete
wb_valid  out  1  MEM/WB entry live, one-cycle pulse per instruction
wb_alu_out  out  32  registered in_alu_out
wb_mdrreg_out  out  32  raw dmem_rdata for loads, 0 otherwise
wb_rmask  out  4  load lane mask, 0 for non-loads
wb_misalign  out  1  access was misaligned and was not performed
wb_pass  out  PASS_W  registered in_pass

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dmem_read, dmem_write, wb_valid and wb_misalign are 0; all data outputs are 0. Reset mid-transaction drops the request immediately. A later dmem_resp in IDLE is ignored.
- FSM states: IDLE, ACCESS.
- in_ready = (state==IDLE). Accept occurs when in_valid && in_ready.
- Lane mask from off=in_alu_out[1:0]:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<off; legal only for off ∈ {0,2}.
  - word: 4'b1111; legal only for off=0.
  - Any other funct3 is treated as word.
- Store data: dmem_wdata = in_rs2 << (8*off); dmem_byte_enable = mask.
- Non-memory op, or misaligned memory op: no memory transaction. Output register loads on the next edge, so wb_valid rises 1 cycle after accept. wb_rmask=0, wb_mdrreg_out=0. wb_misalign=1 only for the misaligned case. State stays IDLE.
- Aligned load or store: on the accept edge, latch address, mask, wdata and pass into internal regs and go to ACCESS.
  - In ACCESS, dmem_read (load) or dmem_write (store) is 1 and address/wdata/byte_enable are held stable.
  - in_is_load && in_is_store both set: treat as load.
- In ACCESS with dmem_resp=1, on that edge:
  - wb_valid=1 next cycle.
  - Load: wb_mdrreg_out=dmem_rdata and wb_rmask=mask.
  - Store: wb_rmask=0.
  - State returns to IDLE.
  - Request lines deassert in the cycle after resp.
- Latency: non-mem 1 cycle; mem = (cycles to dmem_resp) + 1. A dmem_resp in the first ACCESS cycle gives 2 cycles from accept to wb_valid.
- dmem_resp in IDLE: ignored.
- wb_valid is a single-cycle pulse. With no accepted instruction in the previous cycle (or no resp), wb_valid=0 and the other wb_* outputs hold their last values.
- Back-to-back non-mem ops: accepted every cycle, wb_valid every cycle.

Test Plan:
- Reset asserted during ACCESS (dmem_read=1) -> dmem_read=0 immediately; wb_valid=0; in_ready=1 after release; stale dmem_resp=1 produces no wb_valid.
- Non-mem op, in_alu_out=0x1234, followed the next cycle by another -> wb_valid high two consecutive cycles; wb_alu_out=0x1234; wb_rmask=0; in_ready never drops.
- lb at 0x1003, dmem_resp after 3 cycles with rdata=0x80FFEEDD -> dmem_address=0x1000; wb_rmask=4'b1000; wb_mdrreg_out=0x80FFEEDD; wb_valid 4 cycles after accept.
- sh at 0x2002, rs2=0x0000ABCD -> dmem_write=1; byte_enable=4'b1100; wdata=0xABCD0000; held until resp; wb_rmask=0.
- lw at 0x3001 -> no dmem_read ever; wb_valid next cycle with wb_misalign=1 and wb_rmask=0.
- lhu at 0x4000, resp in first ACCESS cycle -> wb_valid exactly 2 cycles after accept; wb_rmask=4'b0011; in_ready low for exactly 1 cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle for the memory stage: EX/MEM entry, data-memory port and MEM/WB register.
// The slave modport is the stage itself; master is the surrounding pipeline and memory.
interface mem_stage_if #(
    parameter int PASS_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_alu_out;
    logic [31:0]       in_rs2;
    logic [2:0]        in_funct3;
    logic              in_is_load;
    logic              in_is_store;
    logic [PASS_W-1:0] in_pass;

    logic              dmem_read;
    logic              dmem_write;
    logic [31:0]       dmem_address;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_byte_enable;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    logic              wb_valid;
    logic [31:0]       wb_alu_out;
    logic [31:0]       wb_mdrreg_out;
    logic [3:0]        wb_rmask;
    logic              wb_misalign;
    logic [PASS_W-1:0] wb_pass;

    modport slave (
        input  in_valid, in_alu_out, in_rs2, in_funct3, in_is_load, in_is_store, in_pass,
        output in_ready,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp,
        output wb_valid, wb_alu_out, wb_mdrreg_out, wb_rmask, wb_misalign, wb_pass
    );

    modport master (
        output in_valid, in_alu_out, in_rs2, in_funct3, in_is_load, in_is_store, in_pass,
        input  in_ready,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp,
        input  wb_valid, wb_alu_out, wb_mdrreg_out, wb_rmask, wb_misalign, wb_pass
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: one word-aligned data-memory transaction per load/store, raw word to WB.
//   state  | meaning
//   IDLE   | ready for a new instruction; non-mem and misaligned ops complete from here
//   ACCESS | request held on dmem_*, waiting for dmem_resp
module mem_stage #(
    parameter int PASS_W = 64
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t            state, state_nx;
    logic              accept, is_mem, size_ok, go_mem;
    logic [1:0]        off;
    logic [3:0]        mask;

    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic              is_load_q;
    logic [31:0]       alu_q;
    logic [PASS_W-1:0] pass_q;

    always_comb begin
        off     = bus.in_alu_out[1:0];
        mask    = 4'b1111;
        size_ok = (off == 2'b00);
        case (bus.in_funct3)
            3'b000, 3'b100: begin
                mask    = 4'b0001 << off;
                size_ok = 1'b1;
            end
            3'b001, 3'b101: begin
                mask    = 4'b0011 << off;
                size_ok = ~off[0];
            end
            default: begin
                mask    = 4'b1111;
                size_ok = (off == 2'b00);
            end
        endcase
    end

    assign is_mem = bus.in_is_load | bus.in_is_store;
    assign accept = bus.in_valid & (state == IDLE);
    assign go_mem = accept & is_mem & size_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.in_ready   = 1'b0;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (go_mem) state_nx = ACCESS;
            end
            ACCESS: begin
                bus.dmem_read  = is_load_q;
                bus.dmem_write = ~is_load_q;
                if (bus.dmem_resp) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.dmem_address     = {addr_q, 2'b00};
    assign bus.dmem_wdata       = wdata_q;
    assign bus.dmem_byte_enable = mask_q;

    // Request-side latches: stable for the whole ACCESS phase regardless of EX/MEM changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            is_load_q <= 1'b0;
            alu_q     <= '0;
            pass_q    <= '0;
        end else if (go_mem) begin
            addr_q    <= bus.in_alu_out[31:2];
            wdata_q   <= bus.in_rs2 << {off, 3'b000};
            mask_q    <= mask;
            is_load_q <= bus.in_is_load;
            alu_q     <= bus.in_alu_out;
            pass_q    <= bus.in_pass;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_alu_out    <= '0;
            bus.wb_mdrreg_out <= '0;
            bus.wb_rmask      <= '0;
            bus.wb_misalign   <= 1'b0;
            bus.wb_pass       <= '0;
        end else begin
            bus.wb_valid <= 1'b0;
            if (accept && !go_mem) begin
                bus.wb_valid      <= 1'b1;
                bus.wb_alu_out    <= bus.in_alu_out;
                bus.wb_mdrreg_out <= '0;
                bus.wb_rmask      <= '0;
                bus.wb_misalign   <= is_mem;
                bus.wb_pass       <= bus.in_pass;
            end else if (state == ACCESS && bus.dmem_resp) begin
                bus.wb_valid      <= 1'b1;
                bus.wb_alu_out    <= alu_q;
                bus.wb_mdrreg_out <= is_load_q ? bus.dmem_rdata : 32'h0;
                bus.wb_rmask      <= is_load_q ? mask_q : 4'b0000;
                bus.wb_misalign   <= 1'b0;
                bus.wb_pass       <= pass_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, non-mem back-to-back, lb, sh, misaligned lw, fast lhu.
module tb_mem_stage;
    localparam int PASS_W = 64;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mem_stage_if #(.PASS_W(PASS_W)) bus ();

    mem_stage #(.PASS_W(PASS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_alu_out  = 32'h0;
        bus.in_rs2      = 32'h0;
        bus.in_funct3   = 3'b000;
        bus.in_is_load  = 1'b0;
        bus.in_is_store = 1'b0;
        bus.in_pass     = '0;
        bus.dmem_rdata  = 32'h0;
        bus.dmem_resp   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [PASS_W-1:0] pass);
        bus.in_valid    = 1'b1;
        bus.in_alu_out  = alu;
        bus.in_rs2      = rs2;
        bus.in_funct3   = f3;
        bus.in_is_load  = ld;
        bus.in_is_store = st;
        bus.in_pass     = pass;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0 ||
            bus.wb_misalign !== 1'b0 || bus.wb_alu_out !== 32'h0 || bus.dmem_address !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: wb_valid=%b rd=%b wr=%b mis=%b alu=%h addr=%h, want all 0",
                     bus.wb_valid, bus.dmem_read, bus.dmem_write, bus.wb_misalign,
                     bus.wb_alu_out, bus.dmem_address);
        end
        step();
        rst = 1'b1;
        step();
        issue(32'h0000_5000, 32'h0, 3'b010, 1'b1, 1'b0, 64'h1);
        step();
        idle_inputs();
        n_cmp++;
        if (bus.dmem_read !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_read: dmem_read=%b want 1", bus.dmem_read);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.dmem_read !== 1'b0 || bus.wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop_req: dmem_read=%b wb_valid=%b want 0 0", bus.dmem_read, bus.wb_valid);
        end
        #3;
        rst = 1'b1;
        step();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: in_ready=%b want 1", bus.in_ready);
        end
        step();
        bus.dmem_resp = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dmem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stale_resp: wb_valid=%b dmem_read=%b want 0 0", bus.wb_valid, bus.dmem_read);
        end
    endtask

    task automatic test_back_to_back();
        issue(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 64'hAAAA_0001);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready0: in_ready=%b want 1", bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_alu_out !== 32'h1234 || bus.wb_rmask !== 4'b0 ||
            bus.in_ready !== 1'b1 || bus.wb_pass !== 64'hAAAA_0001 || bus.wb_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: v=%b alu=%h rmask=%b rdy=%b pass=%h mis=%b want 1 1234 0000 1 aaaa0001 0",
                     bus.wb_valid, bus.wb_alu_out, bus.wb_rmask, bus.in_ready, bus.wb_pass, bus.wb_misalign);
        end
        issue(32'h0000_5678, 32'h0, 3'b010, 1'b0, 1'b0, 64'hAAAA_0002);
        step();
        idle_inputs();
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_alu_out !== 32'h5678 || bus.in_ready !== 1'b1 ||
            bus.wb_pass !== 64'hAAAA_0002) begin
            n_bad++;
            $display("FAIL b2b_second: v=%b alu=%h rdy=%b pass=%h want 1 5678 1 aaaa0002",
                     bus.wb_valid, bus.wb_alu_out, bus.in_ready, bus.wb_pass);
        end
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.wb_alu_out !== 32'h5678) begin
            n_bad++;
            $display("FAIL b2b_hold: v=%b alu=%h want 0 5678", bus.wb_valid, bus.wb_alu_out);
        end
    endtask

    task automatic test_lb();
        issue(32'h0000_1003, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b0, 64'h0B);
        step();
        idle_inputs();
        n_cmp++;
        if (bus.dmem_read !== 1'b1 || bus.dmem_write !== 1'b0 || bus.dmem_address !== 32'h1000 ||
            bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_request: rd=%b wr=%b addr=%h rdy=%b v=%b want 1 0 00001000 0 0",
                     bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.in_ready, bus.wb_valid);
        end
        step();
        step();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h80FF_EEDD;
        n_cmp++;
        if (bus.dmem_read !== 1'b1 || bus.dmem_address !== 32'h1000 || bus.wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_hold: rd=%b addr=%h v=%b want 1 00001000 0",
                     bus.dmem_read, bus.dmem_address, bus.wb_valid);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rmask !== 4'b1000 || bus.wb_mdrreg_out !== 32'h80FF_EEDD ||
            bus.wb_alu_out !== 32'h1003 || bus.wb_pass !== 64'h0B || bus.dmem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_result: v=%b rmask=%b mdr=%h alu=%h pass=%h rd=%b want 1 1000 80ffeedd 00001003 b 0",
                     bus.wb_valid, bus.wb_rmask, bus.wb_mdrreg_out, bus.wb_alu_out, bus.wb_pass, bus.dmem_read);
        end
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.wb_mdrreg_out !== 32'h80FF_EEDD) begin
            n_bad++;
            $display("FAIL lb_pulse: v=%b mdr=%h want 0 80ffeedd", bus.wb_valid, bus.wb_mdrreg_out);
        end
    endtask

    task automatic test_sh();
        issue(32'h0000_2002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 64'h5);
        step();
        issue(32'h0000_7771, 32'h1111_2222, 3'b010, 1'b1, 1'b0, 64'h9);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.dmem_write !== 1'b1 || bus.dmem_read !== 1'b0 || bus.dmem_byte_enable !== 4'b1100 ||
            bus.dmem_wdata !== 32'hABCD_0000 || bus.dmem_address !== 32'h2000) begin
            n_bad++;
            $display("FAIL sh_request: wr=%b rd=%b be=%b wdata=%h addr=%h want 1 0 1100 abcd0000 00002000",
                     bus.dmem_write, bus.dmem_read, bus.dmem_byte_enable, bus.dmem_wdata, bus.dmem_address);
        end
        step();
        bus.dmem_resp = 1'b1;
        n_cmp++;
        if (bus.dmem_write !== 1'b1 || bus.dmem_byte_enable !== 4'b1100 ||
            bus.dmem_wdata !== 32'hABCD_0000 || bus.dmem_address !== 32'h2000) begin
            n_bad++;
            $display("FAIL sh_hold: wr=%b be=%b wdata=%h addr=%h want 1 1100 abcd0000 00002000",
                     bus.dmem_write, bus.dmem_byte_enable, bus.dmem_wdata, bus.dmem_address);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rmask !== 4'b0000 || bus.wb_mdrreg_out !== 32'h0 ||
            bus.dmem_write !== 1'b0 || bus.wb_alu_out !== 32'h2002 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_result: v=%b rmask=%b mdr=%h wr=%b alu=%h rdy=%b want 1 0000 0 0 00002002 1",
                     bus.wb_valid, bus.wb_rmask, bus.wb_mdrreg_out, bus.dmem_write, bus.wb_alu_out, bus.in_ready);
        end
    endtask

    task automatic test_misalign();
        issue(32'h0000_3001, 32'h0, 3'b010, 1'b1, 1'b0, 64'h7);
        step();
        idle_inputs();
        n_cmp++;
        if (bus.dmem_read !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_misalign !== 1'b1 ||
            bus.wb_rmask !== 4'b0000 || bus.wb_mdrreg_out !== 32'h0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_misalign: rd=%b v=%b mis=%b rmask=%b mdr=%h rdy=%b want 0 1 1 0000 0 1",
                     bus.dmem_read, bus.wb_valid, bus.wb_misalign, bus.wb_rmask, bus.wb_mdrreg_out, bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.dmem_read !== 1'b0 || bus.wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_misalign_after: rd=%b v=%b want 0 0", bus.dmem_read, bus.wb_valid);
        end
    endtask

    task automatic test_lhu_fast();
        issue(32'h0000_4000, 32'h0, 3'b101, 1'b1, 1'b1, 64'hC);
        step();
        idle_inputs();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1234_BEEF;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.dmem_read !== 1'b1 || bus.dmem_write !== 1'b0 ||
            bus.wb_valid !== 1'b0 || bus.dmem_address !== 32'h4000) begin
            n_bad++;
            $display("FAIL lhu_access: rdy=%b rd=%b wr=%b v=%b addr=%h want 0 1 0 0 00004000",
                     bus.in_ready, bus.dmem_read, bus.dmem_write, bus.wb_valid, bus.dmem_address);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rmask !== 4'b0011 || bus.wb_mdrreg_out !== 32'h1234_BEEF ||
            bus.in_ready !== 1'b1 || bus.wb_misalign !== 1'b0 || bus.dmem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL lhu_result: v=%b rmask=%b mdr=%h rdy=%b mis=%b rd=%b want 1 0011 1234beef 1 0 0",
                     bus.wb_valid, bus.wb_rmask, bus.wb_mdrreg_out, bus.in_ready, bus.wb_misalign, bus.dmem_read);
        end
        step();
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lhu_after: v=%b rdy=%b want 0 1", bus.wb_valid, bus.in_ready);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_back_to_back();
        test_lb();
        test_sh();
        test_misalign();
        test_lhu_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
